l1_window_accumulator: RTL and testbench

// - Consumer end of the Kernel_unit result stream: accepts one |i_if - i_w| magnitude per handshake.
// - Sums KSIZE magnitudes per output pixel and emits the AdderNet similarity value.
// - Sits between the kernel-unit array and the output feature-map writer.
// - Has valid/ready on both sides, so either side can stall.

---
 rtl/l1_window_accumulator.sv | 95 +++++++++
 tb/tb_l1_window_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/l1_window_accumulator.sv
// Sums KSIZE unsigned |x-w| magnitudes per output pixel behind a one-deep output skid.
// Optional ACC_NEGATE_EN: emit the negated sum (AdderNet similarity) instead of the raw sum.
`ifndef NBIT
`define NBIT 8
`endif

module l1_window_accumulator #(
   parameter int NBIT  = `NBIT,
   parameter int KSIZE = 9,
   parameter int ACC_W = NBIT + 4,
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [NBIT-1:0]  i_data,
   output logic             o_ready,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [ACC_W:0]   o_sum,
   output logic [CNT_W-1:0] o_tap_cnt
);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KSIZE - 1);

   state_t            state_reg, state_next;
   logic [ACC_W-1:0]  acc_reg, acc_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ACC_W:0]    sum_reg, sum_next;

   logic              in_fire;
   logic              out_fire;
   logic              last_tap;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W:0]    window_val;

   assign o_valid   = (state_reg == HOLD);
   assign o_ready   = ~o_valid | i_ready;
   assign o_sum     = sum_reg;
   assign o_tap_cnt = cnt_reg;

   assign in_fire   = i_valid & o_ready;
   assign out_fire  = o_valid & i_ready;
   assign last_tap  = (cnt_reg == LAST_TAP);
   assign acc_sum   = acc_reg + ACC_W'(i_data);

`ifdef ACC_NEGATE_EN
   assign window_val = -{1'b0, acc_sum};
`else
   assign window_val = {1'b0, acc_sum};
`endif

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      sum_next   = sum_reg;
      // A pending result drains regardless of clear; only a last-tap load can keep HOLD.
      if (out_fire) begin
         state_next = ACC;
      end
      if (i_clear) begin
         acc_next = '0;
         cnt_next = '0;
      end else if (in_fire) begin
         if (last_tap) begin
            sum_next   = window_val;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = HOLD;
         end else begin
            acc_next = acc_sum;
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ACC;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         sum_reg   <= sum_next;
      end
   end

endmodule

// File: tb/tb_l1_window_accumulator.sv
// Directed bench for l1_window_accumulator (NBIT=8, KSIZE=9, ACC_W=12); honours ACC_NEGATE_EN.
module tb_l1_window_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        valid_in;
   logic [7:0]  data;
   logic        ready_out;
   logic        valid_out;
   logic        ready_in;
   logic [12:0] sum;
   logic [3:0]  tap_cnt;

   int checks = 0;
   int errors = 0;
   int pulses;

   always #5 clk = ~clk;

   l1_window_accumulator #(.NBIT(8), .KSIZE(9), .ACC_W(12), .CNT_W(4)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clear   (clear),
      .i_valid   (valid_in),
      .i_data    (data),
      .o_ready   (ready_out),
      .o_valid   (valid_out),
      .i_ready   (ready_in),
      .o_sum     (sum),
      .o_tap_cnt (tap_cnt)
   );

   function automatic logic [12:0] expect_sum(input int s);
`ifdef ACC_NEGATE_EN
      return 13'(-s);
`else
      return 13'(s);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic feed(input int n, input logic [7:0] d);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         data     = d;
         @(negedge clk);
      end
      valid_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; valid_in = 1'b0; data = '0; ready_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cnt", 32'(tap_cnt), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(ready_out), 32'd1);

      // Basic window: 9 taps of 10
      feed(8, 8'd10);
      chk("basic_cnt8", 32'(tap_cnt), 32'd8);
      chk("basic_nvalid", 32'(valid_out), 32'd0);
      feed(1, 8'd10);
      chk("basic_valid", 32'(valid_out), 32'd1);
      chk("basic_sum", 32'(sum), 32'(expect_sum(90)));
      chk("basic_cnt0", 32'(tap_cnt), 32'd0);
      @(negedge clk);
      chk("basic_pulse", 32'(valid_out), 32'd0);
      chk("basic_keep", 32'(sum), 32'(expect_sum(90)));

      // Max magnitude
      feed(9, 8'd255);
      chk("max_valid", 32'(valid_out), 32'd1);
      chk("max_sum", 32'(sum), 32'(expect_sum(2295)));

      // Backpressure with i_valid held high
      ready_in = 1'b0;
      valid_in = 1'b1;
      data     = 8'd50;
      #1;
      chk("bp_ready", 32'(ready_out), 32'd0);
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("bp_ready_hold", 32'(ready_out), 32'd0);
      chk("bp_cnt", 32'(tap_cnt), 32'd0);
      chk("bp_valid", 32'(valid_out), 32'd1);
      chk("bp_sum", 32'(sum), 32'(expect_sum(2295)));
      ready_in = 1'b1;
      @(negedge clk);
      chk("bp_drain", 32'(valid_out), 32'd0);
      chk("bp_resume_cnt", 32'(tap_cnt), 32'd1);
      feed(8, 8'd50);
      chk("bp_win_valid", 32'(valid_out), 32'd1);
      chk("bp_win_sum", 32'(sum), 32'(expect_sum(450)));
      @(negedge clk);

      // Back-to-back: 18 continuous taps of 1
      pulses = 0;
      for (int i = 0; i < 18; i++) begin
         valid_in = 1'b1;
         data     = 8'd1;
         @(negedge clk);
         if (valid_out) begin
            pulses++;
            chk("b2b_sum", 32'(sum), 32'(expect_sum(9)));
         end
      end
      valid_in = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);
      @(negedge clk);

      // Clear must not disturb a pending result
      feed(9, 8'd4);
      ready_in = 1'b0;
      clear    = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_hold_valid", 32'(valid_out), 32'd1);
      chk("clr_hold_sum", 32'(sum), 32'(expect_sum(36)));
      ready_in = 1'b1;
      @(negedge clk);
      chk("clr_hold_drain", 32'(valid_out), 32'd0);

      // Clear mid-window discards the partial sum and the concurrent tap
      feed(4, 8'd7);
      chk("clr_cnt4", 32'(tap_cnt), 32'd4);
      clear = 1'b1; valid_in = 1'b1; data = 8'd100;
      @(negedge clk);
      clear = 1'b0; valid_in = 1'b0;
      chk("clr_cnt0", 32'(tap_cnt), 32'd0);
      feed(9, 8'd2);
      chk("clr_valid", 32'(valid_out), 32'd1);
      chk("clr_sum", 32'(sum), 32'(expect_sum(18)));
      @(negedge clk);

      // Reset mid-window
      feed(5, 8'd3);
      chk("rstm_cnt5", 32'(tap_cnt), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstm_cnt", 32'(tap_cnt), 32'd0);
      chk("rstm_valid", 32'(valid_out), 32'd0);
      chk("rstm_sum", 32'(sum), 32'd0);
      feed(9, 8'd3);
      chk("rstm_wvalid", 32'(valid_out), 32'd1);
      chk("rstm_wsum", 32'(sum), 32'(expect_sum(27)));
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
